// File: rtl/mul16_seq_pkg.sv
// Shared constants for the sequential shift-and-add multiplier.
// Holds the FSM encoding and the iteration count.
package mul16_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    localparam int           MUL_ITER = 16;
    localparam logic [3:0]   CNT_LAST = 4'(MUL_ITER - 1);

endpackage

// File: rtl/mul16_seq_add16.sv
// 16-bit unsigned ripple adder with carry-out.
// This is the only adder in the multiplier and is reused every iteration.
module add16 (
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    output logic [15:0] out,
    output logic        ovfl
);

    assign {ovfl, out} = {1'b0, in1} + {1'b0, in2};

endmodule

// File: rtl/mul16_seq.sv
// Sequential 16x16 unsigned multiplier: one shift-and-add step per clock.
// The start/busy/done handshake accepts a new operation in IDLE or DONE.
module mul16_seq
    import mul16_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    mul_state_t  state;
    logic [15:0] mcand;
    logic [15:0] hi;
    logic [15:0] lo;
    logic [3:0]  cnt;

    logic [15:0] addend;
    logic [15:0] sum;
    logic        ovfl;
    logic [31:0] shifted;

    assign addend  = lo[0] ? mcand : 16'h0000;
    // The carry-out becomes the MSB of hi, so no product bit is lost.
    assign shifted = {ovfl, sum, lo[15:1]};

    add16 u_add16 (
        .in1  (hi),
        .in2  (addend),
        .out  (sum),
        .ovfl (ovfl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mcand <= a;
                        hi    <= '0;
                        lo    <= b;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    {hi, lo} <= shifted;
                    cnt      <= cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= shifted;
                        state   <= ST_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul16_seq.sv
// Scoreboard bench for mul16_seq: the driver pushes a*b with its accept cycle,
// the monitor pops on every done and checks product and latency.
module tb_mul16_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] product;

    typedef struct {
        logic [31:0] prod;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    mul16_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Caller must be at posedge+#1 with busy low; returns at posedge+#1 after E0.
    task automatic do_op(input logic [15:0] x, input logic [15:0] y);
        exp_t e;
        start = 1'b1;
        a = x;
        b = y;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        e.prod = 32'(x) * 32'(y);
        e.acc  = cyc;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            n++;
            @(posedge clk); #1;
        end
        if (n >= 60) check("wait_idle_timeout", 32'(n), 32'd0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got product %h expected no done", product);
            end else begin
                e = sb_q.pop_front();
                check("product", product, e.prod);
                check("latency", 32'(cyc - e.acc), 32'd16);
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        int n;
        logic [15:0] ra, rb;

        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", product, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 3*5 with busy duration and hold-after-done checks
        do_op(16'd3, 16'd5);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        check("busy_cycles", 32'(n), 32'd16);
        check("done_at_busy_fall", 32'(done), 32'd1);
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("product_held", product, 32'h0000000F);

        do_op(16'hFFFF, 16'hFFFF);
        wait_idle();
        @(posedge clk); #1;
        do_op(16'h1234, 16'h0000);
        wait_idle();
        @(posedge clk); #1;

        // start while busy must be ignored
        do_op(16'h00FF, 16'h0101);
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b1;
        a = 16'd5;
        b = 16'd5;
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b0;
        check("busy_during_ignored", 32'(busy), 32'd1);
        wait_idle();
        @(posedge clk); #1;

        // reset in the 8th RUN cycle discards the operation
        do_op(16'h1234, 16'h5678);
        repeat (7) begin @(posedge clk); #1; end
        #2;
        sb_q.delete();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_product", product, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        do_op(16'd7, 16'd6);
        wait_idle();
        @(posedge clk); #1;

        // back-to-back: start held on the DONE cycle
        do_op(16'd11, 16'd13);
        wait_idle();
        check("b2b_first_done", 32'(done), 32'd1);
        do_op(16'd2, 16'd9);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_idle();
        @(posedge clk); #1;
        check("b2b_product", product, 32'd18);

        // randomized operands with random gaps (gap 0 = back-to-back)
        for (int i = 0; i < 25; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 7))
                0: ra = 16'hFFFF;
                1: rb = 16'hFFFF;
                2: rb = 16'h0000;
                3: ra = 16'h0001;
                default: ;
            endcase
            do_op(ra, rb);
            wait_idle();
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
